cmd_decoder: RTL and testbench

CMD_DECODER -- requirements
Module: cmd_decoder

---
 rtl/icevga_cmd_pkg.sv | 36 +++
 rtl/cmd_byte_fetch.sv | 59 +++++
 rtl/cmd_decoder.sv | 170 +++++++++++++++++
 tb/tb_cmd_decoder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/icevga_cmd_pkg.sv
// Shared opcode constants, argument counts and FSM encodings for the command decoder.
package icevga_cmd_pkg;

  localparam logic [7:0] OP_NOP      = 8'h00;
  localparam logic [7:0] OP_SET_ADDR = 8'h01;
  localparam logic [7:0] OP_WRITE    = 8'h02;
  localparam logic [7:0] OP_SET_PAL  = 8'h03;
  localparam logic [7:0] OP_SET_BG   = 8'h04;

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_ACK,
    ST_RELEASE
  } fetch_state_t;

  typedef enum logic [1:0] {
    ST_OPCODE,
    ST_ARGS,
    ST_EXEC
  } cmd_state_t;

  function automatic logic op_known(input logic [7:0] op);
    return op <= OP_SET_BG;
  endfunction

  function automatic logic [1:0] arg_count(input logic [7:0] op);
    case (op)
      OP_SET_ADDR: return 2'd2;
      OP_WRITE:    return 2'd1;
      OP_SET_PAL:  return 2'd3;
      OP_SET_BG:   return 2'd2;
      default:     return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/cmd_byte_fetch.sv
// Four-phase byte handshake with the shared command register; emits a one-cycle
// byte_valid pulse per consumed byte.
module cmd_byte_fetch
  import icevga_cmd_pkg::*;
(
  input  logic       clk,
  input  logic       nrst,
  input  logic       cmd_avail,
  input  logic [7:0] cmd_data,
  output logic       cmd_rd,
  output logic       byte_valid,
  output logic [7:0] byte_data
);

  fetch_state_t state_q, state_d;
  logic         rd_q, rd_d;
  logic         valid_q, valid_d;
  logic [7:0]   byte_q, byte_d;

  always_comb begin
    state_d = state_q;
    rd_d    = 1'b0;
    valid_d = 1'b0;
    byte_d  = byte_q;
    case (state_q)
      ST_FETCH: begin
        if (cmd_avail) begin
          byte_d  = cmd_data;
          rd_d    = 1'b1;
          valid_d = 1'b1;
          state_d = ST_ACK;
        end
      end
      ST_ACK:     state_d = ST_RELEASE;
      // Wait for the register to drop avail so the same byte is never re-read.
      ST_RELEASE: if (!cmd_avail) state_d = ST_FETCH;
      default:    state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      state_q <= ST_FETCH;
      rd_q    <= 1'b0;
      valid_q <= 1'b0;
      byte_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      valid_q <= valid_d;
      byte_q  <= byte_d;
    end
  end

  assign cmd_rd     = rd_q;
  assign byte_valid = valid_q;
  assign byte_data  = byte_q;

endmodule

// File: rtl/cmd_decoder.sv
// Command decoder: assembles opcode+argument bytes and drives framebuffer/palette/background.
// Optional CMD_DECODER_ERRCNT_EN adds a saturating unknown-opcode counter (err_count).
module cmd_decoder
  import icevga_cmd_pkg::*;
(
  input  logic        clk,
  input  logic        nrst,
  input  logic        cmd_avail,
  input  logic [7:0]  cmd_data,
  output logic        cmd_rd,
  output logic        fb_we,
  output logic [15:0] fb_addr,
  output logic [7:0]  fb_wdata,
  output logic        pal_we,
  output logic [3:0]  pal_idx,
  output logic [11:0] pal_rgb,
  output logic [11:0] bg_rgb,
  output logic        busy
`ifdef CMD_DECODER_ERRCNT_EN
  ,
  output logic [7:0]  err_count
`endif
);

  logic       byte_valid;
  logic [7:0] byte_data;

  cmd_byte_fetch u_fetch (
    .clk       (clk),
    .nrst      (nrst),
    .cmd_avail (cmd_avail),
    .cmd_data  (cmd_data),
    .cmd_rd    (cmd_rd),
    .byte_valid(byte_valid),
    .byte_data (byte_data)
  );

  cmd_state_t  state_q, state_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [1:0]  arg_cnt_q, arg_cnt_d;
  logic [7:0]  arg0_q, arg0_d;
  logic [7:0]  arg1_q, arg1_d;
  logic        fb_we_q, fb_we_d;
  logic [15:0] fb_addr_q, fb_addr_d;
  logic [7:0]  fb_wdata_q, fb_wdata_d;
  logic        pal_we_q, pal_we_d;
  logic [3:0]  pal_idx_q, pal_idx_d;
  logic [11:0] pal_rgb_q, pal_rgb_d;
  logic [11:0] bg_rgb_q, bg_rgb_d;
  logic        busy_q, busy_d;
`ifdef CMD_DECODER_ERRCNT_EN
  logic [7:0]  err_count_q, err_count_d;
`endif

  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    arg_cnt_d  = arg_cnt_q;
    arg0_d     = arg0_q;
    arg1_d     = arg1_q;
    fb_we_d    = 1'b0;
    fb_addr_d  = fb_addr_q;
    fb_wdata_d = fb_wdata_q;
    pal_we_d   = 1'b0;
    pal_idx_d  = pal_idx_q;
    pal_rgb_d  = pal_rgb_q;
    bg_rgb_d   = bg_rgb_q;
`ifdef CMD_DECODER_ERRCNT_EN
    err_count_d = err_count_q;
`endif
    case (state_q)
      ST_OPCODE: begin
        if (byte_valid) begin
          if (op_known(byte_data)) begin
            opcode_d  = byte_data;
            arg_cnt_d = 2'd0;
            state_d   = (arg_count(byte_data) == 2'd0) ? ST_EXEC : ST_ARGS;
          end
`ifdef CMD_DECODER_ERRCNT_EN
          else if (err_count_q != 8'hFF) begin
            err_count_d = err_count_q + 8'd1;
          end
`endif
        end
      end
      ST_ARGS: begin
        if (byte_valid) begin
          arg_cnt_d = arg_cnt_q + 2'd1;
          if (arg_cnt_q == 2'd0) arg0_d = byte_data;
          if (arg_cnt_q == 2'd1) arg1_d = byte_data;
          // Final byte: act on it directly so outputs are valid during EXEC.
          if (arg_cnt_q + 2'd1 == arg_count(opcode_q)) begin
            state_d = ST_EXEC;
            case (opcode_q)
              OP_SET_ADDR: fb_addr_d = {byte_data, arg0_q};
              OP_WRITE: begin
                fb_wdata_d = byte_data;
                fb_we_d    = 1'b1;
              end
              OP_SET_PAL: begin
                pal_idx_d = arg0_q[3:0];
                pal_rgb_d = {arg1_q, byte_data[3:0]};
                pal_we_d  = 1'b1;
              end
              OP_SET_BG: bg_rgb_d = {arg0_q, byte_data[3:0]};
              default: ;
            endcase
          end
        end
      end
      ST_EXEC: begin
        state_d = ST_OPCODE;
        if (fb_we_q) fb_addr_d = fb_addr_q + 16'd1;
      end
      default: state_d = ST_OPCODE;
    endcase
    busy_d = (state_d != ST_OPCODE);
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      state_q    <= ST_OPCODE;
      opcode_q   <= OP_NOP;
      arg_cnt_q  <= 2'd0;
      arg0_q     <= 8'h00;
      arg1_q     <= 8'h00;
      fb_we_q    <= 1'b0;
      fb_addr_q  <= 16'h0000;
      fb_wdata_q <= 8'h00;
      pal_we_q   <= 1'b0;
      pal_idx_q  <= 4'h0;
      pal_rgb_q  <= 12'h000;
      bg_rgb_q   <= 12'h000;
      busy_q     <= 1'b0;
`ifdef CMD_DECODER_ERRCNT_EN
      err_count_q <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      arg_cnt_q  <= arg_cnt_d;
      arg0_q     <= arg0_d;
      arg1_q     <= arg1_d;
      fb_we_q    <= fb_we_d;
      fb_addr_q  <= fb_addr_d;
      fb_wdata_q <= fb_wdata_d;
      pal_we_q   <= pal_we_d;
      pal_idx_q  <= pal_idx_d;
      pal_rgb_q  <= pal_rgb_d;
      bg_rgb_q   <= bg_rgb_d;
      busy_q     <= busy_d;
`ifdef CMD_DECODER_ERRCNT_EN
      err_count_q <= err_count_d;
`endif
    end
  end

  assign fb_we    = fb_we_q;
  assign fb_addr  = fb_addr_q;
  assign fb_wdata = fb_wdata_q;
  assign pal_we   = pal_we_q;
  assign pal_idx  = pal_idx_q;
  assign pal_rgb  = pal_rgb_q;
  assign bg_rgb   = bg_rgb_q;
  assign busy     = busy_q;
`ifdef CMD_DECODER_ERRCNT_EN
  assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_cmd_decoder.sv
// Directed bench for cmd_decoder: strobes are checked against a scoreboard queue,
// register state is checked with immediate assertions between commands.
module tb_cmd_decoder;

  logic        clk;
  logic        nrst;
  logic        cmd_avail;
  logic [7:0]  cmd_data;
  logic        cmd_rd;
  logic        fb_we;
  logic [15:0] fb_addr;
  logic [7:0]  fb_wdata;
  logic        pal_we;
  logic [3:0]  pal_idx;
  logic [11:0] pal_rgb;
  logic [11:0] bg_rgb;
  logic        busy;
`ifdef CMD_DECODER_ERRCNT_EN
  logic [7:0]  err_count;
`endif

  cmd_decoder dut (
    .clk      (clk),
    .nrst     (nrst),
    .cmd_avail(cmd_avail),
    .cmd_data (cmd_data),
    .cmd_rd   (cmd_rd),
    .fb_we    (fb_we),
    .fb_addr  (fb_addr),
    .fb_wdata (fb_wdata),
    .pal_we   (pal_we),
    .pal_idx  (pal_idx),
    .pal_rgb  (pal_rgb),
    .bg_rgb   (bg_rgb),
    .busy     (busy)
`ifdef CMD_DECODER_ERRCNT_EN
    ,
    .err_count(err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_pal;
    logic [15:0] addr;
    logic [11:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   fb_cnt = 0;
  int   pal_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Strobe monitor: every fb_we/pal_we pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!nrst) begin
      if (fb_we) begin
        fb_cnt++;
        chk("fb_we_pending", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("fb_we_kind", 32'(mon_e.is_pal), 32'd0);
          chk("fb_addr_at_we", 32'(fb_addr), 32'(mon_e.addr));
          chk("fb_wdata_at_we", 32'(fb_wdata), 32'(mon_e.data));
        end
      end
      if (pal_we) begin
        pal_cnt++;
        chk("pal_we_pending", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("pal_we_kind", 32'(mon_e.is_pal), 32'd1);
          chk("pal_idx_at_we", 32'(pal_idx), 32'(mon_e.addr));
          chk("pal_rgb_at_we", 32'(pal_rgb), 32'(mon_e.data));
        end
      end
    end
  end

  task automatic push_fb(input logic [15:0] a, input logic [7:0] d);
    exp_t e;
    e.is_pal = 1'b0;
    e.addr   = a;
    e.data   = {4'h0, d};
    sb.push_back(e);
  endtask

  task automatic push_pal(input logic [3:0] idx, input logic [11:0] rgb);
    exp_t e;
    e.is_pal = 1'b1;
    e.addr   = {12'h000, idx};
    e.data   = rgb;
    sb.push_back(e);
  endtask

  // Offer a byte, wait (bounded) for the ack, optionally keep avail high, then withdraw.
  task automatic send_byte_hold(input logic [7:0] b, input int hold, output int pulses);
    bit got;
    got    = 1'b0;
    pulses = 0;
    @(negedge clk);
    cmd_data  = b;
    cmd_avail = 1'b1;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (cmd_rd) begin
        got = 1'b1;
        pulses++;
      end
    end
    chk("cmd_rd_ack", 32'(got), 32'd1);
    for (int n = 0; n < hold; n++) begin
      @(negedge clk);
      if (cmd_rd) pulses++;
    end
    cmd_avail = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int p;
    send_byte_hold(b, 0, p);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int pulses;
    nrst      = 1'b1;
    cmd_avail = 1'b0;
    cmd_data  = 8'h00;
    idle(3);
    chk("rst_cmd_rd", 32'(cmd_rd), 32'd0);
    chk("rst_fb_we", 32'(fb_we), 32'd0);
    chk("rst_pal_we", 32'(pal_we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fb_addr", 32'(fb_addr), 32'h0);
    chk("rst_fb_wdata", 32'(fb_wdata), 32'h0);
    chk("rst_pal_idx", 32'(pal_idx), 32'h0);
    chk("rst_pal_rgb", 32'(pal_rgb), 32'h0);
    chk("rst_bg_rgb", 32'(bg_rgb), 32'h0);
`ifdef CMD_DECODER_ERRCNT_EN
    chk("rst_err_count", 32'(err_count), 32'h0);
`endif
    nrst = 1'b0;
    idle(2);

    // SET_ADDR 0x1234 then WRITE 0xAB
    send_byte(8'h01);
    chk("busy_after_opcode", 32'(busy), 32'd1);
    send_byte(8'h34);
    send_byte(8'h12);
    idle(3);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("set_addr_1234", 32'(fb_addr), 32'h1234);
    send_byte(8'h02);
    push_fb(16'h1234, 8'hAB);
    send_byte(8'hAB);
    idle(3);
    chk("addr_inc_1235", 32'(fb_addr), 32'h1235);

    // Address wrap
    send_byte(8'h01);
    send_byte(8'hFF);
    send_byte(8'hFF);
    idle(3);
    chk("set_addr_ffff", 32'(fb_addr), 32'hFFFF);
    send_byte(8'h02);
    push_fb(16'hFFFF, 8'h55);
    send_byte(8'h55);
    idle(3);
    chk("addr_wrap_0000", 32'(fb_addr), 32'h0000);

    // SET_PAL: idx F7 -> 7, rg A5 / b 3C -> {A,5,C}
    send_byte(8'h03);
    send_byte(8'hF7);
    send_byte(8'hA5);
    push_pal(4'h7, 12'hA5C);
    send_byte(8'h3C);
    idle(3);
    chk("pal_idx_held", 32'(pal_idx), 32'h7);
    chk("pal_rgb_held", 32'(pal_rgb), 32'hA5C);

    // Unknown opcode, then SET_BG
    send_byte(8'h09);
    chk("busy_unknown_op", 32'(busy), 32'd0);
    idle(2);
`ifdef CMD_DECODER_ERRCNT_EN
    chk("err_count_1", 32'(err_count), 32'd1);
`endif
    send_byte(8'h04);
    send_byte(8'h12);
    send_byte(8'h03);
    idle(3);
    chk("bg_rgb_123", 32'(bg_rgb), 32'h123);
    chk("addr_kept_by_bg", 32'(fb_addr), 32'h0000);

    // avail held high after ack: one byte, one cmd_rd pulse
    send_byte_hold(8'h02, 5, pulses);
    chk("cmd_rd_pulses_hold", 32'(pulses), 32'd1);
    chk("busy_after_held_op", 32'(busy), 32'd1);
    push_fb(16'h0000, 8'h77);
    send_byte(8'h77);
    idle(3);
    chk("addr_after_held", 32'(fb_addr), 32'h0001);

    // Reset mid-command discards the partial SET_ADDR
    send_byte(8'h01);
    send_byte(8'h34);
    nrst = 1'b1;
    @(negedge clk);
    nrst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_fb_addr", 32'(fb_addr), 32'h0000);
    chk("midrst_bg_rgb", 32'(bg_rgb), 32'h000);
    chk("midrst_pal_rgb", 32'(pal_rgb), 32'h000);
`ifdef CMD_DECODER_ERRCNT_EN
    chk("midrst_err_count", 32'(err_count), 32'd0);
`endif
    send_byte(8'h02);
    push_fb(16'h0000, 8'hAB);
    send_byte(8'hAB);
    idle(3);
    chk("addr_after_midrst", 32'(fb_addr), 32'h0001);

    // Opcode boundaries: 0x05 and 0xFF unknown, NOP goes straight to EXEC
    send_byte(8'hFF);
    chk("busy_op_ff", 32'(busy), 32'd0);
    send_byte(8'h05);
    chk("busy_op_05", 32'(busy), 32'd0);
    send_byte(8'h00);
    chk("busy_nop_exec", 32'(busy), 32'd1);
    idle(2);
    chk("busy_after_nop", 32'(busy), 32'd0);
`ifdef CMD_DECODER_ERRCNT_EN
    chk("err_count_2", 32'(err_count), 32'd2);
`endif

    idle(3);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("fb_we_total", 32'(fb_cnt), 32'd4);
    chk("pal_we_total", 32'(pal_cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
